// File: rtl/ysyx_22041752_trap_seq_if.sv
// Bundle between the EXU and the trap/return sequencer: request handshake,
// CSR port drive from the sequencer, and the flush/redirect output.
interface ysyx_22041752_trap_seq_if #(
  parameter int PC_WD = 64
);
  logic             req_valid;
  logic             req_ecall;
  logic             req_int;
  logic             req_mret;
  logic [PC_WD-1:0] req_pc;
  logic             req_ready;
  logic             seq_busy;
  logic             csr_we;
  logic [11:0]      csr_addr;
  logic [PC_WD-1:0] csr_wdata;
  logic [PC_WD-1:0] csr_rdata;
  logic             csr_sel;
  logic             flush;
  logic [PC_WD-1:0] flush_pc;

  // EXU / CSR-file side
  modport master (
    output req_valid, req_ecall, req_int, req_mret, req_pc, csr_rdata,
    input  req_ready, seq_busy, csr_we, csr_addr, csr_wdata, csr_sel,
           flush, flush_pc
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_ecall, req_int, req_mret, req_pc, csr_rdata,
    output req_ready, seq_busy, csr_we, csr_addr, csr_wdata, csr_sel,
           flush, flush_pc
  );
endinterface

// File: rtl/ysyx_22041752_trap_seq.sv
// Multi-cycle trap/return sequencer: walks the mtvec/mepc/mcause/mstatus
// accesses for ecall, interrupt and mret, then pulses a redirecting flush.
module ysyx_22041752_trap_seq #(
  parameter int               PC_WD       = 64,
  parameter logic [PC_WD-1:0] INT_CAUSE   = 64'h8000_0000_0000_0007,
  parameter logic [PC_WD-1:0] ECALL_CAUSE = 64'h0000_0000_0000_000b
) (
  input logic                       clk,
  input logic                       reset,
  ysyx_22041752_trap_seq_if.slave   bus
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [PC_WD-1:0] ALIGN_MASK = ~PC_WD'(3);

  typedef enum logic [2:0] {
    IDLE,
    T_TVEC,
    T_EPC,
    T_CAUSE,
    T_STAT,
    R_EPC,
    R_STAT,
    FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [PC_WD-1:0] epc_r, cause_r, tgt_r;
  logic             any_type, accept;
  logic [PC_WD-1:0] trap_stat, mret_stat;

  assign any_type = bus.req_int | bus.req_ecall | bus.req_mret;
  assign accept   = (state == IDLE) & bus.req_valid & any_type;

  // mstatus rewrites: trap stacks MIE into MPIE and sets MPP=M;
  // mret restores MIE from MPIE, sets MPIE and drops MPP to U.
  always_comb begin
    trap_stat        = bus.csr_rdata;
    trap_stat[7]     = bus.csr_rdata[3];
    trap_stat[3]     = 1'b0;
    trap_stat[12:11] = 2'b11;
    mret_stat        = bus.csr_rdata;
    mret_stat[3]     = bus.csr_rdata[7];
    mret_stat[7]     = 1'b1;
    mret_stat[12:11] = 2'b00;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_r   <= '0;
      cause_r <= '0;
      tgt_r   <= '0;
    end else begin
      if (accept) begin
        epc_r   <= bus.req_pc;
        cause_r <= bus.req_int ? INT_CAUSE : ECALL_CAUSE;
      end
      if (state == T_TVEC) tgt_r <= bus.csr_rdata & ALIGN_MASK;  // direct mode only
      if (state == R_EPC)  tgt_r <= bus.csr_rdata;
    end
  end

  // NOTE: every output and state_nxt gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.seq_busy  = (state != IDLE);
    bus.csr_sel   = 1'b0;
    bus.csr_we    = 1'b0;
    bus.csr_addr  = '0;
    bus.csr_wdata = '0;
    bus.flush     = 1'b0;
    bus.flush_pc  = '0;

    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept)
          state_nxt = (bus.req_int | bus.req_ecall) ? T_TVEC : R_EPC;
      end
      T_TVEC: begin
        bus.csr_sel  = 1'b1;
        bus.csr_addr = CSR_MTVEC;
        state_nxt    = T_EPC;
      end
      T_EPC: begin
        bus.csr_sel   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MEPC;
        bus.csr_wdata = epc_r & ALIGN_MASK;
        state_nxt     = T_CAUSE;
      end
      T_CAUSE: begin
        bus.csr_sel   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MCAUSE;
        bus.csr_wdata = cause_r;
        state_nxt     = T_STAT;
      end
      T_STAT: begin
        bus.csr_sel   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MSTATUS;
        bus.csr_wdata = trap_stat;
        state_nxt     = FLUSH;
      end
      R_EPC: begin
        bus.csr_sel  = 1'b1;
        bus.csr_addr = CSR_MEPC;
        state_nxt    = R_STAT;
      end
      R_STAT: begin
        bus.csr_sel   = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_addr  = CSR_MSTATUS;
        bus.csr_wdata = mret_stat;
        state_nxt     = FLUSH;
      end
      FLUSH: begin
        bus.flush    = 1'b1;
        bus.flush_pc = tgt_r;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041752_trap_seq.sv
// Self-checking bench for ysyx_22041752_trap_seq: CSR file model, write/flush
// scoreboard, a vector table, and hand sequences for back-to-back and reset.
module tb_ysyx_22041752_trap_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_22041752_trap_seq_if #(.PC_WD(64)) bus ();

  ysyx_22041752_trap_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- CSR file model ----------------
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_mstatus;
  logic        ld;
  logic [63:0] ld_mtvec, ld_mepc, ld_mcause, ld_mstatus;

  always_comb begin
    case (bus.csr_addr)
      12'h305: bus.csr_rdata = m_mtvec;
      12'h341: bus.csr_rdata = m_mepc;
      12'h342: bus.csr_rdata = m_mcause;
      12'h300: bus.csr_rdata = m_mstatus;
      default: bus.csr_rdata = 64'h0;
    endcase
  end

  always @(posedge clk) begin
    if (ld) begin
      m_mtvec   <= ld_mtvec;
      m_mepc    <= ld_mepc;
      m_mcause  <= ld_mcause;
      m_mstatus <= ld_mstatus;
    end else if (bus.csr_sel && bus.csr_we) begin
      case (bus.csr_addr)
        12'h305: m_mtvec   <= bus.csr_wdata;
        12'h341: m_mepc    <= bus.csr_wdata;
        12'h342: m_mcause  <= bus.csr_wdata;
        12'h300: m_mstatus <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] flush_q[$];

  always @(negedge clk) begin
    if (reset) begin
      if (bus.csr_we) begin
        if (exp_q.size() == 0) check("spurious_we", bus.csr_we, 1'b0);
        else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_addr", bus.csr_addr, w.addr);
          check("wr_data", bus.csr_wdata, w.data);
        end
      end
      if (bus.flush) begin
        check("flush_no_we", bus.csr_we, 1'b0);
        if (flush_q.size() == 0) check("spurious_flush", bus.flush, 1'b0);
        else check("flush_pc", bus.flush_pc, flush_q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic trap, input logic [63:0] pc,
                          input logic [63:0] cause, input logic [63:0] stat,
                          input logic [63:0] fpc);
    if (trap) begin
      exp_q.push_back('{addr: 12'h341, data: pc & ~64'h3});
      exp_q.push_back('{addr: 12'h342, data: cause});
    end
    exp_q.push_back('{addr: 12'h300, data: stat});
    flush_q.push_back(fpc);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.req_ecall = 1'b0;
    bus.req_int   = 1'b0;
    bus.req_mret  = 1'b0;
    bus.req_pc    = 64'h0;
  endtask

  task automatic preload(input logic [63:0] tvec, input logic [63:0] epc,
                         input logic [63:0] cause, input logic [63:0] stat);
    @(negedge clk);
    ld = 1'b1;
    ld_mtvec = tvec; ld_mepc = epc; ld_mcause = cause; ld_mstatus = stat;
    @(posedge clk);
    #1 ld = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    bus.req_ready, 1'b1);
    check({tag, "_busy"},     bus.seq_busy,  1'b0);
    check({tag, "_we"},       bus.csr_we,    1'b0);
    check({tag, "_sel"},      bus.csr_sel,   1'b0);
    check({tag, "_addr"},     bus.csr_addr,  12'h0);
    check({tag, "_wdata"},    bus.csr_wdata, 64'h0);
    check({tag, "_flush"},    bus.flush,     1'b0);
    check({tag, "_flush_pc"}, bus.flush_pc,  64'h0);
  endtask

  typedef struct {
    logic        v, e, i, m;
    logic [63:0] pc, mtvec, mepc, mstatus;
    logic        acc;
    int          lat;
    logic [63:0] fpc, cause, stat;
  } vec_t;

  task automatic run_vec(input vec_t t, input string tag);
    int got;
    preload(t.mtvec, t.mepc, 64'h0, t.mstatus);
    @(negedge clk);
    check({tag, "_ready_pre"}, bus.req_ready, 1'b1);
    bus.req_valid = t.v;
    bus.req_ecall = t.e;
    bus.req_int   = t.i;
    bus.req_mret  = t.m;
    bus.req_pc    = t.pc;
    if (t.acc) push_exp(t.e | t.i, t.pc, t.cause, t.stat, t.fpc);
    @(posedge clk);
    if (t.acc) begin
      got = 0;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) idle_req();
        if (bus.flush) begin
          got = k;
          break;
        end
      end
      check({tag, "_flush_cycle"}, 64'(got), 64'(t.lat));
      @(negedge clk);
      check({tag, "_ready_post"}, bus.req_ready, 1'b1);
    end else begin
      @(negedge clk);
      idle_req();
      check({tag, "_no_busy"}, bus.seq_busy, 1'b0);
      repeat (4) @(negedge clk);
      check({tag, "_still_ready"}, bus.req_ready, 1'b1);
    end
    check({tag, "_sb_empty"}, 64'(exp_q.size() + flush_q.size()), 64'h0);
  endtask

  vec_t vecs[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g1, g2;
    // valid e i m  pc  mtvec  mepc  mstatus  acc lat  flush_pc  cause  stat
    vecs[0] = '{1, 1, 0, 0, 64'h8000_0040, 64'h8000_0101, 64'h0, 64'h8,
                1, 5, 64'h8000_0100, 64'hb, 64'h1880};
    vecs[1] = '{1, 1, 1, 0, 64'h8000_0040, 64'h8000_0101, 64'h0, 64'h8,
                1, 5, 64'h8000_0100, 64'h8000_0000_0000_0007, 64'h1880};
    vecs[2] = '{1, 0, 0, 1, 64'h0, 64'h0, 64'h8000_0044, 64'h1880,
                1, 3, 64'h8000_0044, 64'h0, 64'h88};
    vecs[3] = '{1, 0, 0, 0, 64'h40, 64'h100, 64'h0, 64'h8,
                0, 0, 64'h0, 64'h0, 64'h0};
    vecs[4] = '{0, 1, 1, 1, 64'h40, 64'h100, 64'h0, 64'h8,
                0, 0, 64'h0, 64'h0, 64'h0};
    vecs[5] = '{1, 0, 1, 0, 64'h8000_1236, 64'h2000_0003, 64'h0, 64'h0,
                1, 5, 64'h2000_0000, 64'h8000_0000_0000_0007, 64'h1800};
    vecs[6] = '{1, 1, 0, 1, 64'h100, 64'h400, 64'h0, 64'h88,
                1, 5, 64'h400, 64'hb, 64'h1880};
    vecs[7] = '{1, 0, 0, 1, 64'h0, 64'h0, 64'h1234_5678, 64'h0,
                1, 3, 64'h1234_5678, 64'h0, 64'h80};

    idle_req();
    ld = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;

    for (int n = 0; n < 8; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // Back-to-back: request held through the first sequence is re-accepted
    // only once the sequencer is idle again.
    preload(64'h8000_0101, 64'h0, 64'h0, 64'h8);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_ecall = 1'b1;
    bus.req_pc    = 64'h8000_0040;
    push_exp(1'b1, 64'h8000_0040, 64'hb, 64'h1880, 64'h8000_0100);
    push_exp(1'b1, 64'h8000_0040, 64'hb, 64'h1800, 64'h8000_0100);
    @(posedge clk);
    g1 = 0;
    g2 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) check("b2b_busy_held", bus.seq_busy, 1'b1);
      if (k == 6) check("b2b_ready_gap", bus.req_ready, 1'b1);
      if (k == 7) idle_req();
      if (bus.flush) begin
        if (g1 == 0) g1 = k;
        else g2 = k;
      end
      if (g2 != 0) break;
    end
    check("b2b_flush1_cycle", 64'(g1), 64'd5);
    check("b2b_flush2_cycle", 64'(g2), 64'd11);
    @(negedge clk);
    check("b2b_sb_empty", 64'(exp_q.size() + flush_q.size()), 64'h0);

    // Reset asserted while in T_CAUSE.
    preload(64'h8000_0101, 64'h0, 64'h0, 64'h8);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_ecall = 1'b1;
    bus.req_pc    = 64'h8000_0040;
    push_exp(1'b1, 64'h8000_0040, 64'hb, 64'h1880, 64'h8000_0100);
    @(posedge clk);
    @(negedge clk);
    idle_req();
    repeat (2) @(negedge clk);
    check("rst_mid_in_cause", bus.csr_addr, 12'h342);
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    exp_q.delete();
    flush_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_mstatus_kept", m_mstatus, 64'h8);
    check("rst_mid_mcause_kept", m_mcause, 64'h0);
    check("rst_mid_mepc_done", m_mepc, 64'h8000_0040);
    reset = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", bus.req_ready, 1'b1);
    run_vec(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
